sram_pipelined: RTL and testbench

//  Single-clock, 1W/1R blocked SRAM for the switch packet buffer. Successor to the
//  1-cycle block SRAM. Adds a configurable read latency, byte-granular write

---
 rtl/sram_pipelined_if.sv | 29 ++
 rtl/sram_pipelined.sv | 107 ++++++++++
 tb/tb_sram_pipelined.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/sram_pipelined_if.sv
// Request/response bundle for the packet-buffer SRAM. The allocator or ingress
// writer and the egress reader drive the master side; the SRAM is the slave side.
interface sram_pipelined_if #(
  parameter int ADDR_W     = 4,
  parameter int BLOCK_BITS = 32,
  parameter int TAG_W      = 4
);
  logic                    we;
  logic [ADDR_W-1:0]       w_addr;
  logic [BLOCK_BITS-1:0]   wdata;
  logic [BLOCK_BITS/8-1:0] wbe;
  logic                    re;
  logic [ADDR_W-1:0]       r_addr;
  logic [TAG_W-1:0]        r_tag;
  logic [BLOCK_BITS-1:0]   rdata;
  logic                    rvalid;
  logic [TAG_W-1:0]        rtag;
  logic                    rerr;

  modport master (
    output we, w_addr, wdata, wbe, re, r_addr, r_tag,
    input  rdata, rvalid, rtag, rerr
  );

  modport slave (
    input  we, w_addr, wdata, wbe, re, r_addr, r_tag,
    output rdata, rvalid, rtag, rerr
  );
endinterface

// File: rtl/sram_pipelined.sv
// 1W/1R block SRAM for the switch packet buffer: byte-enabled writes, 1..4 cycle
// fully pipelined reads with tags, selectable read-during-write, out-of-range flag.
package mem_pkg;
  parameter int ADDR_W     = 4;
  parameter int BLOCK_BITS = 32;
  parameter int NUM_BLOCKS = 12;
endpackage

module sram_pipelined #(
  parameter int ADDR_W     = mem_pkg::ADDR_W,
  parameter int BLOCK_BITS = mem_pkg::BLOCK_BITS,
  parameter int NUM_BLOCKS = mem_pkg::NUM_BLOCKS,
  parameter int RD_LATENCY = 1,
  parameter int RDW_MODE   = 0,
  parameter int TAG_W      = 4
) (
  input logic              clk,
  input logic              rst,
  sram_pipelined_if.slave  bus
);
  localparam int BE_W  = BLOCK_BITS / 8;
  localparam int IDX_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam logic [ADDR_W:0] LIMIT = NUM_BLOCKS[ADDR_W:0];

  if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
    $error("sram_pipelined: RD_LATENCY must be in 1..4");
  end
  if (BLOCK_BITS % 8 != 0) begin : g_bad_width
    $error("sram_pipelined: BLOCK_BITS must be a multiple of 8");
  end
  if (NUM_BLOCKS > 2 ** ADDR_W) begin : g_bad_depth
    $error("sram_pipelined: NUM_BLOCKS exceeds the address space");
  end

  logic [BLOCK_BITS-1:0] mem [NUM_BLOCKS];

  logic                  wr_ok;
  logic                  rd_in_range;
  logic [IDX_W-1:0]      w_idx;
  logic [IDX_W-1:0]      r_idx;
  logic [BLOCK_BITS-1:0] rd_data_c;
  logic                  rd_err_c;

  logic                  vld_q  [RD_LATENCY];
  logic [BLOCK_BITS-1:0] data_q [RD_LATENCY];
  logic [TAG_W-1:0]      tag_q  [RD_LATENCY];
  logic                  err_q  [RD_LATENCY];

  // Index truncation is safe: the index is only used once the range check passes.
  assign wr_ok       = bus.we && ({1'b0, bus.w_addr} < LIMIT);
  assign rd_in_range = {1'b0, bus.r_addr} < LIMIT;
  assign w_idx       = bus.w_addr[IDX_W-1:0];
  assign r_idx       = bus.r_addr[IDX_W-1:0];

  // The array is never reset; only writes in non-reset cycles touch it.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) begin
      for (int i = 0; i < BE_W; i++) begin
        if (bus.wbe[i]) mem[w_idx][8*i +: 8] <= bus.wdata[8*i +: 8];
      end
    end
  end

  // Array is read in the acceptance cycle; write-first mode forwards the merged block.
  always_comb begin
    rd_data_c = '0;
    rd_err_c  = 1'b0;
    if (!rd_in_range) begin
      rd_err_c = 1'b1;
    end else begin
      rd_data_c = mem[r_idx];
      if (RDW_MODE == 1 && wr_ok && bus.w_addr == bus.r_addr) begin
        for (int i = 0; i < BE_W; i++) begin
          if (bus.wbe[i]) rd_data_c[8*i +: 8] = bus.wdata[8*i +: 8];
        end
      end
    end
  end

  // Later stages are pure delay, so writes after acceptance cannot reach a read in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        vld_q[i]  <= 1'b0;
        data_q[i] <= '0;
        tag_q[i]  <= '0;
        err_q[i]  <= 1'b0;
      end
    end else begin
      vld_q[0]  <= bus.re;
      data_q[0] <= rd_data_c;
      tag_q[0]  <= bus.r_tag;
      err_q[0]  <= rd_err_c;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_q[i]  <= vld_q[i-1];
        data_q[i] <= data_q[i-1];
        tag_q[i]  <= tag_q[i-1];
        err_q[i]  <= err_q[i-1];
      end
    end
  end

  assign bus.rvalid = vld_q[RD_LATENCY-1];
  assign bus.rdata  = vld_q[RD_LATENCY-1] ? data_q[RD_LATENCY-1] : '0;
  assign bus.rtag   = vld_q[RD_LATENCY-1] ? tag_q[RD_LATENCY-1]  : '0;
  assign bus.rerr   = vld_q[RD_LATENCY-1] ? err_q[RD_LATENCY-1]  : 1'b0;
endmodule

// File: tb/tb_sram_pipelined.sv
// Drives two SRAM instances (latency 3 read-first, latency 1 write-first) with the
// same traffic and checks every cycle of output against a scoreboard of expected reads.
module tb_sram_pipelined;
  localparam int AW   = 4;
  localparam int BB   = 32;
  localparam int NB   = 12;
  localparam int TW   = 4;
  localparam int BEW  = BB / 8;
  localparam int LAT0 = 3;
  localparam int LAT1 = 1;

  typedef struct {
    int unsigned   due;
    logic [BB-1:0] data;
    logic [TW-1:0] tag;
    logic          err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;

  logic [BB-1:0] model_mem [NB];
  exp_t          sb [2][$];

  sram_pipelined_if #(.ADDR_W(AW), .BLOCK_BITS(BB), .TAG_W(TW)) bus0 ();
  sram_pipelined_if #(.ADDR_W(AW), .BLOCK_BITS(BB), .TAG_W(TW)) bus1 ();

  sram_pipelined #(
    .ADDR_W(AW), .BLOCK_BITS(BB), .NUM_BLOCKS(NB),
    .RD_LATENCY(LAT0), .RDW_MODE(0), .TAG_W(TW)
  ) dut0 (
    .clk(clk),
    .rst(rst),
    .bus(bus0.slave)
  );

  sram_pipelined #(
    .ADDR_W(AW), .BLOCK_BITS(BB), .NUM_BLOCKS(NB),
    .RD_LATENCY(LAT1), .RDW_MODE(1), .TAG_W(TW)
  ) dut1 (
    .clk(clk),
    .rst(rst),
    .bus(bus1.slave)
  );

  always #5 clk = ~clk;

  // Reset drops every read that has not come back yet.
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    mon_en <= 1'b1;
    if (rst === 1'b1) begin
      sb[0].delete();
      sb[1].delete();
    end
  end

  function automatic logic [BB-1:0] merge(input logic [BB-1:0] old, input logic [BB-1:0] nw,
                                          input logic [BEW-1:0] be);
    logic [BB-1:0] r;
    r = old;
    for (int i = 0; i < BEW; i++) begin
      if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
    end
    return r;
  endfunction

  task automatic applyStimulus(input bit rst_v, input bit we, input int wa, input logic [BB-1:0] wd,
                               input logic [BEW-1:0] be, input bit re, input int ra,
                               input logic [TW-1:0] tg);
    exp_t          e;
    logic [BB-1:0] old;
    @(negedge clk);
    rst = rst_v;
    bus0.we = we;  bus0.w_addr = AW'(wa); bus0.wdata = wd; bus0.wbe = be;
    bus0.re = re;  bus0.r_addr = AW'(ra); bus0.r_tag = tg;
    bus1.we = we;  bus1.w_addr = AW'(wa); bus1.wdata = wd; bus1.wbe = be;
    bus1.re = re;  bus1.r_addr = AW'(ra); bus1.r_tag = tg;
    if (!rst_v) begin
      if (re) begin
        old   = (ra < NB) ? model_mem[ra] : '0;
        e.due = cyc + LAT0;
        e.data = old;
        e.tag = tg;
        e.err = (ra >= NB);
        sb[0].push_back(e);
        e.due = cyc + LAT1;
        if (we && wa == ra && ra < NB) e.data = merge(old, wd, be);
        sb[1].push_back(e);
      end
      if (we && wa < NB) model_mem[wa] = merge(model_mem[wa], wd, be);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, '0, '0, 0, 0, '0);
  endtask

  task automatic checkOutput(input int id, input logic rv, input logic [BB-1:0] rd,
                             input logic [TW-1:0] rt, input logic er);
    exp_t e;
    checks++;
    if (rv === 1'b1) begin
      if (sb[id].size() == 0) begin
        errors++;
        $display("[TB] FAIL dut%0d unexpected_rvalid cyc=%0d got data=%h tag=%0d err=%b, required no response",
                 id, cyc, rd, rt, er);
      end else begin
        e = sb[id].pop_front();
        if (e.due != cyc || rd !== e.data || rt !== e.tag || er !== e.err) begin
          errors++;
          $display("[TB] FAIL dut%0d read_resp got cyc=%0d data=%h tag=%0d err=%b, required cyc=%0d data=%h tag=%0d err=%b",
                   id, cyc, rd, rt, er, e.due, e.data, e.tag, e.err);
        end
      end
    end else begin
      if (rv !== 1'b0 || rd !== '0 || rt !== '0 || er !== 1'b0) begin
        errors++;
        $display("[TB] FAIL dut%0d idle_outputs cyc=%0d got rvalid=%b data=%h tag=%h err=%b, required all 0",
                 id, cyc, rv, rd, rt, er);
      end
      if (sb[id].size() > 0 && sb[id][0].due <= cyc) begin
        errors++;
        $display("[TB] FAIL dut%0d missing_rvalid cyc=%0d got rvalid=0, required tag=%0d due at cyc=%0d",
                 id, cyc, sb[id][0].tag, sb[id][0].due);
        void'(sb[id].pop_front());
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      checkOutput(0, bus0.rvalid, bus0.rdata, bus0.rtag, bus0.rerr);
      checkOutput(1, bus1.rvalid, bus1.rdata, bus1.rtag, bus1.rerr);
    end
  end

  initial begin
    bus0.we = 1'b0; bus0.w_addr = '0; bus0.wdata = '0; bus0.wbe = '0;
    bus0.re = 1'b0; bus0.r_addr = '0; bus0.r_tag = '0;
    bus1.we = 1'b0; bus1.w_addr = '0; bus1.wdata = '0; bus1.wbe = '0;
    bus1.re = 1'b0; bus1.r_addr = '0; bus1.r_tag = '0;

    // Reads and writes during reset must be ignored.
    applyStimulus(1, 1, 3, 32'h0BAD_0BAD, 4'hF, 1, 3, 4'd5);
    applyStimulus(1, 1, 3, 32'h0BAD_0BAD, 4'hF, 1, 3, 4'd6);

    for (int a = 0; a < NB; a++) applyStimulus(0, 1, a, $urandom, 4'hF, 0, 0, '0);

    applyStimulus(0, 1, 2, 32'hA5A5_A5A5, 4'hF, 0, 0, '0);
    applyStimulus(0, 0, 0, '0, '0, 1, 2, 4'd7);
    idle(4);

    applyStimulus(0, 1, 1, 32'hFFFF_FFFF, 4'hF, 0, 0, '0);
    applyStimulus(0, 1, 1, 32'h0000_0000, 4'b0001, 0, 0, '0);
    applyStimulus(0, 0, 0, '0, '0, 1, 1, 4'd1);
    applyStimulus(0, 1, 1, 32'h1234_5678, 4'b0000, 0, 0, '0);
    applyStimulus(0, 0, 0, '0, '0, 1, 1, 4'd2);
    idle(4);

    applyStimulus(0, 1, 4, 32'h1111_1111, 4'hF, 0, 0, '0);
    applyStimulus(0, 1, 4, 32'h2222_2222, 4'hF, 1, 4, 4'd3);
    applyStimulus(0, 0, 0, '0, '0, 1, 4, 4'd4);
    applyStimulus(0, 1, 9, 32'h3333_3333, 4'b0110, 1, 9, 4'd8);
    idle(4);

    applyStimulus(0, 1, NB, 32'hDEAD_BEEF, 4'hF, 1, NB, 4'd5);
    applyStimulus(0, 0, 0, '0, '0, 1, 15, 4'd9);
    for (int a = 0; a < NB; a++) applyStimulus(0, 0, 0, '0, '0, 1, a, TW'(a));
    idle(4);

    // Back-to-back tagged reads with a reset landing while some are still in flight.
    for (int t = 0; t < 5; t++) applyStimulus(0, 0, 0, '0, '0, 1, t, TW'(t));
    applyStimulus(1, 0, 0, '0, '0, 1, 5, 4'd5);
    applyStimulus(1, 0, 0, '0, '0, 1, 6, 4'd6);
    applyStimulus(0, 0, 0, '0, '0, 1, 2, 4'd7);
    idle(6);

    for (int n = 0; n < 400; n++) begin
      applyStimulus(($urandom_range(0, 59) == 0), $urandom_range(0, 1) == 1,
                    $urandom_range(0, 15), $urandom, BEW'($urandom_range(0, 15)),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 15), TW'($urandom));
    end
    idle(8);

    for (int id = 0; id < 2; id++) begin
      checks++;
      if (sb[id].size() != 0) begin
        errors++;
        $display("[TB] FAIL dut%0d drain got %0d outstanding reads, required 0", id, sb[id].size());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
